// File: rtl/permute_check_pkg.sv
// Shared types, constants and helpers for the permutation checker.
// Permutation p maps to three variable swaps applied in order s1, s2, s3.
package permute_check_pkg;

    localparam int PERM_COUNT = 24;
    localparam int MAX_VARS = 8;
    localparam int MAX_W = 1 << MAX_VARS;
    localparam int LANE_OPTIONS [8] = '{1, 2, 3, 4, 6, 8, 12, 24};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    // s1: none/(A,B)/(A,C)/(A,D); s2: none/(B,C)/(B,D); s3: none/(C,D)
    typedef struct packed {
        logic [1:0] s1;
        logic [1:0] s2;
        logic       s3;
    } swap_sel_t;

    localparam swap_sel_t PERM_SEL [PERM_COUNT] = '{
        5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05,
        5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D,
        5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15,
        5'h18, 5'h19, 5'h1A, 5'h1B, 5'h1C, 5'h1D
    };

    function automatic logic lanes_legal(input int lanes);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (LANE_OPTIONS[n] == lanes) ok = 1'b1;
        end
        return ok;
    endfunction

    // Exchange the roles of variables i and j in a truth table.
    function automatic logic [MAX_W-1:0] var_swap(
        input logic [MAX_W-1:0]    tbl,
        input logic [2:0]          i,
        input logic [2:0]          j
    );
        logic [MAX_W-1:0]    res;
        logic [MAX_VARS-1:0] xv;
        logic [MAX_VARS-1:0] yv;
        res = '0;
        for (int x = 0; x < MAX_W; x++) begin
            xv = MAX_VARS'(x);
            yv = xv;
            yv[i] = xv[j];
            yv[j] = xv[i];
            res[x] = tbl[yv];
        end
        return res;
    endfunction

    function automatic logic [4:0] popcount24(input logic [23:0] m);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 24; i++) c += 5'(m[i]);
        return c;
    endfunction

endpackage

// File: rtl/permute_check_seq_permute_vars4.sv
// Applies permutation p of the top four variables to a truth table.
// Purely combinational; one instance per scan lane.
module permute_vars4 #(
    parameter int VAR_COUNT = 7
) (
    input  logic [(1<<VAR_COUNT)-1:0] tbl,
    input  logic [4:0]                idx,
    output logic [(1<<VAR_COUNT)-1:0] perm
);
    import permute_check_pkg::*;

    localparam int W = 1 << VAR_COUNT;
    localparam logic [2:0] VA = 3'(VAR_COUNT - 4);
    localparam logic [2:0] VB = 3'(VAR_COUNT - 3);
    localparam logic [2:0] VC = 3'(VAR_COUNT - 2);
    localparam logic [2:0] VD = 3'(VAR_COUNT - 1);

    swap_sel_t        sel;
    logic [MAX_W-1:0] t;

    // Look up the swap triple, then apply s1, s2, s3 in that order.
    always_comb begin
        sel = '0;
        for (int q = 0; q < PERM_COUNT; q++) begin
            if (idx == 5'(q)) sel = PERM_SEL[q];
        end
        t = MAX_W'(tbl);
        case (sel.s1)
            2'd1:    t = var_swap(t, VA, VB);
            2'd2:    t = var_swap(t, VA, VC);
            2'd3:    t = var_swap(t, VA, VD);
            default: t = t;
        endcase
        case (sel.s2)
            2'd1:    t = var_swap(t, VB, VC);
            2'd2:    t = var_swap(t, VB, VD);
            default: t = t;
        endcase
        if (sel.s3) t = var_swap(t, VC, VD);
        perm = t[W-1:0];
    end

endmodule

// File: rtl/permute_check_seq.sv
// Time-multiplexed checker: LANES permutations of bot tested against top
// per cycle; mask, popcount and tag returned over valid/ready.
module permute_check_seq #(
    parameter int VAR_COUNT = 7,
    parameter int LANES     = 4,
    parameter int TAG_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [(1<<VAR_COUNT)-1:0] in_top,
    input  logic [(1<<VAR_COUNT)-1:0] in_bot,
    input  logic                      in_any_only,
    input  logic [TAG_WIDTH-1:0]      in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [23:0]               out_mask,
    output logic [4:0]                out_count,
    output logic                      out_any,
    output logic [TAG_WIDTH-1:0]      out_tag
);
    import permute_check_pkg::*;

    localparam int W  = 1 << VAR_COUNT;
    localparam int N  = PERM_COUNT / LANES;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    if (!lanes_legal(LANES)) begin : g_bad_lanes
        $error("LANES=%0d is not a divisor of 24", LANES);
    end
    if (VAR_COUNT < 4 || VAR_COUNT > MAX_VARS) begin : g_bad_vars
        $error("VAR_COUNT=%0d out of range", VAR_COUNT);
    end

    state_t               state;
    state_t               state_n;
    logic [KW-1:0]        k;
    logic [W-1:0]         top_q;
    logic [W-1:0]         bot_q;
    logic                 any_only_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [23:0]          mask_q;
    logic [23:0]          step_mask;
    logic [23:0]          mask_next;
    logic [LANES-1:0]     hit;
    logic [4:0]           lane_idx [LANES];
    logic [W-1:0]         lane_perm [LANES];
    logic                 accept;
    logic                 last_step;
    logic                 scan_done;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = 5'(int'(k) * LANES + l);
        permute_vars4 #(.VAR_COUNT(VAR_COUNT)) u_perm (
            .tbl  (bot_q),
            .idx  (lane_idx[l]),
            .perm (lane_perm[l])
        );
        assign hit[l] = ((lane_perm[l] & ~top_q) == '0);
    end

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign out_valid = (state == ST_DONE);
    assign out_tag   = tag_q;
    assign accept    = in_valid && in_ready;
    assign last_step = (k == KW'(N - 1));
    assign mask_next = mask_q | step_mask;
    assign scan_done = (state == ST_SCAN) &&
                       (last_step || (any_only_q && (step_mask != '0)));

    // Scatter this step's lane results into mask positions 23-p.
    always_comb begin
        step_mask = '0;
        for (int l = 0; l < LANES; l++) begin
            if (hit[l]) step_mask[5'd23 - lane_idx[l]] = 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: if (accept) state_n = ST_SCAN;
            ST_SCAN: if (scan_done) state_n = ST_DONE;
            ST_DONE: if (out_ready) state_n = in_valid ? ST_SCAN : ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Request capture, scan accumulation and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k          <= '0;
            top_q      <= '0;
            bot_q      <= '0;
            any_only_q <= 1'b0;
            tag_q      <= '0;
            mask_q     <= '0;
            out_mask   <= '0;
            out_count  <= '0;
            out_any    <= 1'b0;
        end else begin
            if (accept) begin
                top_q      <= in_top;
                bot_q      <= in_bot;
                any_only_q <= in_any_only;
                tag_q      <= in_tag;
                mask_q     <= '0;
                k          <= '0;
            end else if (state == ST_SCAN) begin
                mask_q <= mask_next;
                k      <= k + 1'b1;
            end
            if (scan_done) begin
                out_mask  <= mask_next;
                out_count <= popcount24(mask_next);
                out_any   <= |mask_next;
            end
        end
    end

endmodule
